// File: rtl/fft_sched_pkg.sv
// Shared types and constants for the FFT frame scheduler.
package fft_sched_pkg;

  localparam int FRAME_LEN_DEF = 16;

  localparam int ERR_SHORT   = 0;
  localparam int ERR_LONG    = 1;
  localparam int ERR_TIMEOUT = 2;

  // ST_DISCARD is the post-drain sub-mode that swallows the tail of an over-long frame.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_BURST,
    ST_WAIT,
    ST_DRAIN,
    ST_DISCARD
  } state_t;

endpackage

// File: rtl/fft_rr_arbiter.sv
// Round-robin arbiter: first active request strictly after the pointer wins.
module fft_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] id,
  output logic          valid
);

  always_comb begin
    int          pos;
    logic [IW-1:0] sel;
    grant = '0;
    id    = '0;
    valid = 1'b0;
    pos   = 0;
    sel   = '0;
    // i runs 1..N so the current owner is considered last.
    for (int i = 1; i <= N; i++) begin
      pos = (int'(ptr) + i) % N;
      sel = IW'(pos);
      if (!valid && req[sel]) begin
        valid      = 1'b1;
        grant[sel] = 1'b1;
        id         = sel;
      end
    end
  end

endmodule

// File: rtl/fft_frame_sched.sv
// Frame scheduler sharing one 16-point FFT engine among NUM_REQ AXI-Stream requesters.
module fft_frame_sched
  import fft_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ*DATA_W-1:0]  s_tdata,
  input  logic [NUM_REQ-1:0]         s_tvalid,
  input  logic [NUM_REQ-1:0]         s_tlast,
  output logic [NUM_REQ-1:0]         s_tready,
  output logic [DATA_W-1:0]          e_tdata,
  output logic                       e_tvalid,
  output logic                       e_tlast,
  input  logic [DATA_W-1:0]          e_rdata,
  input  logic                       e_rvalid,
  input  logic                       e_rlast,
  output logic [DATA_W-1:0]          m_tdata,
  output logic                       m_tvalid,
  output logic                       m_tlast,
  output logic [$clog2(NUM_REQ)-1:0] m_tdest,
  input  logic                       m_tready,
  output logic                       busy,
  output logic [2:0]                 err
);

  localparam int RW = $clog2(NUM_REQ);
  localparam int IW = $clog2(FRAME_LEN);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t state, state_next;

  logic [RW-1:0]      gnt, rr_ptr, arb_id;
  logic [NUM_REQ-1:0] gnt_oh, arb_grant;
  logic               arb_valid;
  logic [IW-1:0]      idx;
  logic [TW-1:0]      tmo;
  logic               long_frame;
  logic [2:0]         err_q;

  logic [DATA_W-1:0]  inbuf  [FRAME_LEN];
  logic [DATA_W-1:0]  outbuf [FRAME_LEN];
  logic [DATA_W-1:0]  s_data_arr [NUM_REQ];

  logic [DATA_W-1:0]  g_data;
  logic               g_valid, g_last, at_last, tmo_hit;

  fft_rr_arbiter #(.N(NUM_REQ), .IW(RW)) u_arb (
    .req   (s_tvalid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .id    (arb_id),
    .valid (arb_valid)
  );

  always_comb begin
    for (int r = 0; r < NUM_REQ; r++) begin
      s_data_arr[r] = s_tdata[r*DATA_W +: DATA_W];
    end
  end

  assign g_data  = s_data_arr[gnt];
  assign g_valid = s_tvalid[gnt];
  assign g_last  = s_tlast[gnt];
  assign at_last = (idx == LAST_IDX);
  assign tmo_hit = (tmo == TMO_LAST);
  assign busy    = (state != ST_IDLE);
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    s_tready   = '0;
    e_tvalid   = 1'b0;
    e_tdata    = '0;
    e_tlast    = 1'b0;
    m_tvalid   = 1'b0;
    m_tdata    = '0;
    m_tlast    = 1'b0;
    m_tdest    = '0;
    case (state)
      ST_IDLE: begin
        if (arb_valid) state_next = ST_COLLECT;
      end
      ST_COLLECT: begin
        s_tready = gnt_oh;
        if (g_valid && (g_last || at_last)) state_next = ST_BURST;
      end
      ST_BURST: begin
        e_tvalid = 1'b1;
        e_tdata  = inbuf[idx];
        e_tlast  = at_last;
        if (at_last) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (e_rvalid && e_rlast)                  state_next = ST_DRAIN;
        else if (!e_rvalid && idx == '0 && tmo_hit) state_next = ST_IDLE;
      end
      ST_DRAIN: begin
        m_tvalid = 1'b1;
        m_tdata  = outbuf[idx];
        m_tlast  = at_last;
        m_tdest  = gnt;
        if (m_tready && at_last) state_next = long_frame ? ST_DISCARD : ST_IDLE;
      end
      ST_DISCARD: begin
        s_tready = gnt_oh;
        if (g_valid && g_last) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // One index counter serves as cnt/i/k/j; it is rezeroed at every phase change.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt        <= '0;
      gnt_oh     <= '0;
      rr_ptr     <= '0;
      idx        <= '0;
      tmo        <= '0;
      long_frame <= 1'b0;
      err_q      <= '0;
      for (int i = 0; i < FRAME_LEN; i++) begin
        inbuf[i]  <= '0;
        outbuf[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            gnt        <= arb_id;
            gnt_oh     <= arb_grant;
            rr_ptr     <= arb_id;
            idx        <= '0;
            long_frame <= 1'b0;
            // Pre-clearing gives the zero fill of short frames for free.
            for (int i = 0; i < FRAME_LEN; i++) begin
              inbuf[i]  <= '0;
              outbuf[i] <= '0;
            end
          end
        end
        ST_COLLECT: begin
          if (g_valid) begin
            inbuf[idx] <= g_data;
            if (g_last && !at_last) begin
              err_q[ERR_SHORT] <= 1'b1;
              idx              <= '0;
            end else if (at_last) begin
              idx <= '0;
              if (!g_last) begin
                err_q[ERR_LONG] <= 1'b1;
                long_frame      <= 1'b1;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_BURST: begin
          idx <= at_last ? '0 : idx + 1'b1;
          tmo <= '0;
        end
        ST_WAIT: begin
          if (e_rvalid) begin
            outbuf[idx] <= e_rdata;
            if (e_rlast) begin
              if (!at_last) err_q[ERR_SHORT] <= 1'b1;
              idx <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end else if (idx == '0) begin
            if (tmo_hit) err_q[ERR_TIMEOUT] <= 1'b1;
            else         tmo <= tmo + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (m_tready) idx <= at_last ? '0 : idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
